mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single cache/memory port (MemRead/MemWrite/WordAddress/DataIn, Stall/DataOut)
//  between two requesters: port 0 (data-side load/store) and port 1 (secondary master, e.g.
//  fetch or debug). Round-robin arbitration, one outstanding access at a time. Holds the
//  command stable while the memory stalls on a miss, returns read data with a done pulse,
//  and aborts accesses that stall longer than a programmable timeout.
// PARAMETERS
//  ADDR_W        10   word-address width (matches memory WordAddress)
//  DATA_W        32   data width
//  TIMEOUT_CYC   255  max consecutive stall cycles before abort; 1..2^16-1
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  req0/req1    in   1       request; held high until doneN
//  we0/we1      in   1       1 = write, 0 = read
//  addr0/addr1  in   ADDR_W  word address
//  wdata0/1     in   DATA_W  write data
//  done0/done1  out  1       one-cycle completion pulse
//  err0/err1    out  1       with doneN: access aborted by timeout
//  rdata0/1     out  DATA_W  read data, valid when doneN & ~errN & ~weN; held until next done
//  mem_read     out  1       to memory MemRead
//  mem_write    out  1       to memory MemWrite
//  mem_addr     out  ADDR_W  to memory WordAddress
//  mem_wdata    out  DATA_W  to memory DataIn
//  mem_stall    in   1       from memory Stall (miss refill in progress)
//  mem_rdata    in   DATA_W  from memory DataOut
//  busy         out  1       1 while in state BUSY
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, rdata0/1=0, stall counter=0, priority pointer -> port 0.
//  States: IDLE, BUSY. Outputs registered.
//  IDLE: eligible = reqN & ~doneN (port completing this cycle is masked, preventing re-issue
//   of a request not yet dropped). If any eligible: winner = sole eligible, else the port
//   pointed to by priority pointer. Latch we/addr/wdata of winner -> mem_* regs, set
//   mem_read=~we, mem_write=we (exactly one high), record owner, go BUSY next edge.
//  BUSY: mem_* held constant. At each edge:
//   - mem_stall==0: access complete. doneOwner=1 next cycle; if read, rdataOwner<=mem_rdata
//     (write: rdata unchanged); mem_read/mem_write<=0; pointer <= other port; -> IDLE.
//   - mem_stall==1: counter++. If counter reaches TIMEOUT_CYC-1 (i.e. TIMEOUT_CYC stalled
//     cycles): abort: doneOwner=1, errOwner=1, mem_read/write<=0, pointer <= other port,
//     counter<=0, -> IDLE. Counter clears on every grant.
//  Latency: grant 1 cycle after req in IDLE; no-stall access: req@t -> mem_* @t+1 ->
//   done @t+2. Min 2 cycles/access; no back-to-back issue from BUSY.
//  Requester changes to addr/wdata/we while BUSY are ignored (latched copy used).
//  req dropped before done while BUSY: access still completes, done still pulsed.
//  reset mid-BUSY: mem_read/mem_write=0 and done/err=0 from next edge; no pulse emitted.
//  doneN/errN never high for both ports in the same cycle; never high during reset.
// TESTING
//  1 Read, port0 addr=0x004, mem_stall=1 for 3 cycles then 0 with mem_rdata=0xDEADBEEF ->
//    mem_read=1/addr=0x004 stable throughout, done0 one cycle after stall low, rdata0=0xDEADBEEF.
//  2 req0 and req1 both high from reset, no stall -> port0 served first, then port1; repeat
//    both high -> port0 again (pointer followed port1). Never two done in one cycle.
//  3 Write port1 addr=0x3FF wdata=0x12345678, wdata1 changed mid-stall -> mem_write=1,
//    mem_wdata=0x12345678 stable, mem_read=0, done1 pulses, rdata1 unchanged.
//  4 TIMEOUT_CYC=4, mem_stall stuck 1 -> after 4 stalled cycles done0&err0 pulse,
//    mem_read drops, next pending req1 granted.
//  5 reset asserted 2 cycles into a stalled read -> all outputs 0 next edge, no done0;
//    after release, req1 alone -> granted, normal completion.
//  6 req0 held high across done0 -> no duplicate grant in done cycle; reissue one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single cache/memory port.
// One outstanding access; command held while memory stalls; stall timeout aborts.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state;
  logic               r_owner;
  logic               r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_win;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;

  // A port whose done pulse is out this cycle is masked so a still-held req is not re-issued.
  assign w_elig0 = req0 & ~done0;
  assign w_elig1 = req1 & ~done1;
  assign w_win   = w_elig1 & (~w_elig0 | r_ptr);
  assign w_we    = w_win ? we1    : we0;
  assign w_addr  = w_win ? addr1  : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;

  // Arbitration FSM: grant in IDLE, hold command in BUSY until completion or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_owner   <= w_win;
            mem_read  <= ~w_we;
            mem_write <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (!mem_stall) begin
            if (r_owner) begin
              done1 <= 1'b1;
              if (mem_read) rdata1 <= mem_rdata;
            end else begin
              done0 <= 1'b1;
              if (mem_read) rdata0 <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_ptr     <= ~r_owner;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end else if (r_cnt == CNT_LIMIT) begin
            if (r_owner) begin
              done1 <= 1'b1;
              err1  <= 1'b1;
            end else begin
              done0 <= 1'b1;
              err0  <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_ptr     <= ~r_owner;
            r_cnt     <= '0;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected commands and completions are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic              port;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } done_t;

  logic              clk, reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, done1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_stall;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int total = 0;
  int bad   = 0;

  cmd_t  cmd_q[$];
  done_t done_q[$];
  logic [DATA_W-1:0] exp_rd [2];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected grant on the memory port.
  task automatic push_cmd(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    cmd_q.push_back(c);
  endtask

  // Expected completion; a successful read updates the model's held rdata for that port.
  task automatic push_done(input logic port, input logic err, input logic is_read, input logic [DATA_W-1:0] d);
    done_t e;
    if (!err && is_read) exp_rd[port] = d;
    e.port = port; e.err = err; e.rdata = exp_rd[port];
    done_q.push_back(e);
  endtask

  task automatic wait_done(input logic port, input int lim, input int exp_n, input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < lim) begin
      tick(1);
      n++;
      if ((port ? done1 : done0) === 1'b1) seen = 1'b1;
    end
    chk(name, seen ? 64'(n) : 64'(0), 64'(exp_n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b0;
  endtask

  // Monitor: command checked at grant and for stability; completions popped from the scoreboard.
  cmd_t cur_cmd;
  logic prev_active = 1'b0;
  always @(negedge clk) begin
    logic  active;
    done_t e;
    active = mem_read | mem_write;
    if (reset) begin
      chk("no_done_in_reset", 64'({done0, done1, err0, err1}), 64'(0));
    end
    if (mem_read & mem_write) chk("rd_wr_exclusive", 64'(1), 64'(0));
    if (active && !prev_active) begin
      if (cmd_q.size() == 0) begin
        chk("unexpected_grant", 64'(mem_addr), 64'(0));
        cur_cmd = '{we: mem_write, addr: mem_addr, wdata: mem_wdata};
      end else begin
        cur_cmd = cmd_q.pop_front();
        chk("grant_we", 64'(mem_write), 64'(cur_cmd.we));
        chk("grant_addr", 64'(mem_addr), 64'(cur_cmd.addr));
        chk("grant_wdata", 64'(mem_wdata), 64'(cur_cmd.wdata));
      end
    end else if (active && prev_active) begin
      chk("hold_cmd", {mem_write, mem_read, 12'(mem_addr), mem_wdata},
          {cur_cmd.we, ~cur_cmd.we, 12'(cur_cmd.addr), cur_cmd.wdata});
    end
    prev_active = active;
    if (done0 & done1) chk("one_done_only", 64'(1), 64'(0));
    if (done0 | done1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 64'({done1, done0}), 64'(0));
      end else begin
        e = done_q.pop_front();
        chk("done_port", 64'(done1), 64'(e.port));
        chk("done_err", 64'(done1 ? err1 : err0), 64'(e.err));
        if (!e.err) chk("done_rdata", 64'(done1 ? rdata1 : rdata0), 64'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_stall = 1'b0; mem_rdata = '0;
    do_reset();
    chk("reset_outputs", 64'({busy, mem_read, mem_write, done0, done1, err0, err1}), 64'(0));
    chk("reset_rdata", {rdata0, rdata1}, 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));

    // 1: stalled read on port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h004; wdata0 = 32'h0; mem_stall = 1'b1;
    push_cmd(1'b0, 10'h004, 32'h0);
    tick(1);
    chk("t1_mem_read", 64'(mem_read), 64'(1));
    tick(3);
    mem_stall = 1'b0; mem_rdata = 32'hDEADBEEF;
    push_done(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_done(1'b0, 10, 1, "t1_done_latency");
    req0 = 1'b0;
    tick(1);

    // 2: round robin from reset
    do_reset();
    req0 = 1'b1; addr0 = 10'h010; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h020; wdata1 = 32'h0;
    mem_rdata = 32'hA0A0A0A0;
    push_cmd(1'b0, 10'h010, 32'h0); push_done(1'b0, 1'b0, 1'b1, 32'hA0A0A0A0);
    push_cmd(1'b0, 10'h020, 32'h0); push_done(1'b1, 1'b0, 1'b1, 32'hB1B1B1B1);
    wait_done(1'b0, 10, 2, "t2_p0_first");
    req0 = 1'b0; mem_rdata = 32'hB1B1B1B1;
    wait_done(1'b1, 10, 2, "t2_p1_second");
    req1 = 1'b0;
    tick(1);
    req0 = 1'b1; addr0 = 10'h030; req1 = 1'b1; addr1 = 10'h040; mem_rdata = 32'hC2C2C2C2;
    push_cmd(1'b0, 10'h030, 32'h0); push_done(1'b0, 1'b0, 1'b1, 32'hC2C2C2C2);
    push_cmd(1'b0, 10'h040, 32'h0); push_done(1'b1, 1'b0, 1'b1, 32'hD3D3D3D3);
    wait_done(1'b0, 10, 2, "t2_p0_again");
    req0 = 1'b0; mem_rdata = 32'hD3D3D3D3;
    wait_done(1'b1, 10, 2, "t2_p1_again");
    req1 = 1'b0;
    tick(1);

    // 3: stalled write on port 1, inputs changed mid-access
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 32'h12345678;
    mem_stall = 1'b1; mem_rdata = 32'hBAD0BAD0;
    push_cmd(1'b1, 10'h3FF, 32'h12345678); push_done(1'b1, 1'b0, 1'b0, 32'h0);
    tick(2);
    wdata1 = 32'hFFFF0000; addr1 = 10'h000; we1 = 1'b0;
    tick(1);
    mem_stall = 1'b0;
    wait_done(1'b1, 10, 1, "t3_wr_done");
    req1 = 1'b0;
    tick(1);

    // 4: timeout abort on port 0, pending port 1 granted next
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h155; mem_stall = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h2AA; wdata1 = 32'h0;
    push_cmd(1'b0, 10'h155, 32'h0); push_done(1'b0, 1'b1, 1'b1, 32'h0);
    push_cmd(1'b0, 10'h2AA, 32'h0); push_done(1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    wait_done(1'b0, 20, 5, "t4_abort_latency");
    chk("t4_mem_read_dropped", 64'(mem_read), 64'(0));
    req0 = 1'b0; mem_stall = 1'b0; mem_rdata = 32'h5A5A5A5A;
    wait_done(1'b1, 10, 2, "t4_p1_after_abort");
    req1 = 1'b0;
    tick(1);

    // 5: reset two cycles into a stalled read
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h077; mem_stall = 1'b1;
    push_cmd(1'b0, 10'h077, 32'h0);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("t5_reset_outputs", 64'({busy, mem_read, mem_write, done0, done1, err0, err1}), 64'(0));
    chk("t5_reset_addr", 64'(mem_addr), 64'(0));
    chk("t5_reset_rdata", {rdata0, rdata1}, 64'(0));
    exp_rd[0] = '0; exp_rd[1] = '0;
    req0 = 1'b0;
    tick(1);
    reset = 1'b0; mem_stall = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h101; mem_rdata = 32'h600DCAFE;
    push_cmd(1'b0, 10'h101, 32'h0); push_done(1'b1, 1'b0, 1'b1, 32'h600DCAFE);
    wait_done(1'b1, 10, 2, "t5_p1_after_reset");
    req1 = 1'b0;
    tick(1);

    // 6: req0 held across its done pulse
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h0C0; mem_rdata = 32'h01010101;
    push_cmd(1'b0, 10'h0C0, 32'h0); push_done(1'b0, 1'b0, 1'b1, 32'h01010101);
    push_cmd(1'b0, 10'h0C0, 32'h0); push_done(1'b0, 1'b0, 1'b1, 32'h02020202);
    wait_done(1'b0, 10, 2, "t6_first_done");
    mem_rdata = 32'h02020202;
    tick(1);
    chk("t6_no_grant_in_done", 64'(mem_read), 64'(0));
    tick(1);
    chk("t6_reissue", 64'(mem_read), 64'(1));
    wait_done(1'b0, 10, 1, "t6_second_done");
    req0 = 1'b0;
    tick(3);

    chk("cmd_queue_empty", 64'(cmd_q.size()), 64'(0));
    chk("done_queue_empty", 64'(done_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
